axo_mem_sram: RTL and testbench

AXO_MEM_SRAM -- requirements
Module: axo_mem_sram

---
 rtl/axo_mem_sram_pkg.sv | 14 +
 rtl/axo_mem_bus.sv | 17 +
 rtl/axo_defines.sv | 6 +
 rtl/axo_sram_array.sv | 27 ++
 rtl/axo_mem_sram.sv | 125 ++++++++++++
 tb/tb_axo_mem_sram.sv | 166 ++++++++++++++++
 6 files changed

// File: rtl/axo_mem_sram_pkg.sv
// rtl/axo_mem_sram_pkg.sv - request legality helpers for the axo SRAM target
package axo_mem_sram_pkg;

    function automatic int lane_count(input logic [1:0] asize);
        return 1 << asize;
    endfunction

    function automatic logic misaligned(input logic [1:0] asize, input logic [2:0] lo);
        logic [2:0] mask;
        mask = 3'((4'd1 << asize) - 4'd1);
        return (lo & mask) != 3'd0;
    endfunction

endpackage

// File: rtl/axo_mem_bus.sv
// rtl/axo_mem_bus.sv - axo memory bus between a requester and a memory target
interface axo_mem_bus #(
    parameter int dlen = 32,
    parameter int alen = 32
);
    logic            re;
    logic            we;
    logic [1:0]      asize;
    logic [alen-1:0] addr;
    logic [dlen-1:0] wdata;
    logic            ready;
    logic            error;
    logic [dlen-1:0] rdata;

    modport MEM (input re, we, asize, addr, wdata, output ready, error, rdata);
    modport REQ (output re, we, asize, addr, wdata, input ready, error, rdata);
endinterface

// File: rtl/axo_defines.sv
// rtl/axo_defines.sv - shared axo bus error codes
`ifndef AXO_DEFINES_SV
`define AXO_DEFINES_SV
`define AXO_MEM_EALIGN   32'hBAD0_A116
`define AXO_MEM_EMISSING 32'hBAD0_0155
`endif

// File: rtl/axo_sram_array.sv
// rtl/axo_sram_array.sv - synchronous single-port RAM with byte enables
module axo_sram_array #(
    parameter int words = 1024,
    parameter int dlen  = 32,
    localparam int aw   = (words > 1) ? $clog2(words) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [dlen/8-1:0] be_i,
    input  logic [aw-1:0]     addr_i,
    input  logic [dlen-1:0]   wdata_i,
    output logic [dlen-1:0]   rdata_o
);
    logic [dlen-1:0] mem [words];
    logic [dlen-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < dlen/8; i++) begin
                if (be_i[i]) mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/axo_mem_sram.sv
// rtl/axo_mem_sram.sv - SRAM target on the axo memory bus with configurable wait states
`ifndef AXO_DEFINES_SV
`include "axo_defines.sv"
`endif
module axo_mem_sram
    import axo_mem_sram_pkg::*;
#(
    parameter int dlen      = 32,
    parameter int alen      = 32,
    parameter int size_log2 = 12,
    parameter int latency   = 0
) (
    input  logic clk,
    input  logic rst,
    axo_mem_bus.MEM bus
);
    localparam int nb    = dlen / 8;
    localparam int lg    = $clog2(nb);
    localparam int words = 2 ** (size_log2 - lg);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic                   we_q;
    logic [1:0]             asize_q;
    logic [size_log2-1:0]   addr_q;
    logic                   ready_q;
    logic                   error_q;
    logic                   rsel_q;
    logic [dlen-1:0]        rdata_q;

    logic                   in_idle, req, illegal, fire, ram_we, cur_we;
    logic [1:0]             cur_asize;
    logic [size_log2-1:0]   cur_addr;
    logic [nb-1:0]          be;
    logic [dlen-1:0]        ram_q;
    int                     off;

    assign in_idle   = (state_q == S_IDLE);
    assign req       = bus.re | bus.we;
    assign illegal   = (bus.re & bus.we) | (lane_count(bus.asize) > nb) | misaligned(bus.asize, bus.addr[2:0]);
    assign cur_we    = in_idle ? bus.we : we_q;
    assign cur_asize = in_idle ? bus.asize : asize_q;
    assign cur_addr  = in_idle ? bus.addr[size_log2-1:0] : addr_q;

    // The RAM samples on the same edge that raises ready, so commit and read happen there.
    assign fire   = in_idle ? (req && !illegal && latency == 0)
                            : (state_q == S_WAIT && req && cnt_q == 4'd0);
    assign ram_we = !rst && cur_we && fire;

    always_comb begin
        off = int'(cur_addr[lg-1:0]);
        be  = '0;
        for (int i = 0; i < nb; i++) begin
            be[i] = (i >= off) && (i < off + lane_count(cur_asize));
        end
    end

    axo_sram_array #(.words(words), .dlen(dlen)) u_array (
        .clk     (clk),
        .we_i    (ram_we),
        .be_i    (be),
        .addr_i  (cur_addr[size_log2-1:lg]),
        .wdata_i (bus.wdata),
        .rdata_o (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            asize_q <= 2'd0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rsel_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rsel_q  <= 1'b0;
            rdata_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= bus.we;
                        asize_q <= bus.asize;
                        addr_q  <= bus.addr[size_log2-1:0];
                        if (illegal) begin
                            state_q <= S_RESP;
                            ready_q <= 1'b1;
                            error_q <= 1'b1;
                            rdata_q <= dlen'(`AXO_MEM_EALIGN);
                        end else if (latency == 0) begin
                            state_q <= S_RESP;
                            ready_q <= 1'b1;
                            rsel_q  <= !bus.we;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= (latency > 0) ? 4'(latency - 1) : 4'd0;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                        ready_q <= 1'b1;
                        rsel_q  <= !we_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.error = error_q;
    assign bus.rdata = rsel_q ? ram_q : rdata_q;
endmodule

// File: tb/tb_axo_mem_sram.sv
// tb/tb_axo_mem_sram.sv - directed bench for axo_mem_sram at latencies 0, 3, 5 and 4
module tb_axo_mem_sram;
    localparam logic [31:0] EALIGN = 32'hBAD0_A116;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  re = '0, we = '0;
    logic [1:0]  asize [4];
    logic [31:0] addr [4];
    logic [31:0] wdata [4];
    wire  [3:0]  rdy, err;
    wire  [31:0] rdat [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g
        localparam int L = (k == 0) ? 0 : (k == 1) ? 3 : (k == 2) ? 5 : 4;
        axo_mem_bus #(.dlen(32), .alen(32)) b ();
        axo_mem_sram #(.dlen(32), .alen(32), .size_log2(12), .latency(L)) dut (
            .clk (clk),
            .rst (rst),
            .bus (b)
        );
        assign b.re    = re[k];
        assign b.we    = we[k];
        assign b.asize = asize[k];
        assign b.addr  = addr[k];
        assign b.wdata = wdata[k];
        assign rdy[k]  = b.ready;
        assign err[k]  = b.error;
        assign rdat[k] = b.rdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic acc(input int k, input bit r, input bit w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic e, output logic [31:0] q);
        @(negedge clk);
        re[k] = r; we[k] = w; asize[k] = sz; addr[k] = a; wdata[k] = d;
        lat = -1; e = 1'bx; q = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (rdy[k]) begin
                lat = c; e = err[k]; q = rdat[k];
                break;
            end
        end
        re[k] = 1'b0; we[k] = 1'b0;
        @(posedge clk);
    endtask

    int          lat;
    logic        e;
    logic [31:0] q;
    logic [3:0]  pat;
    logic        seen;

    initial begin
        for (int k = 0; k < 4; k++) begin
            asize[k] = 2'd0; addr[k] = '0; wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, rdy[0]}, 32'd0);
        check("rst_error", {31'd0, err[0]}, 32'd0);
        check("rst_rdata", rdat[0], 32'd0);
        @(negedge clk) rst = 1'b0;

        // latency 0
        acc(0, 0, 1, 2'd2, 32'h40, 32'hDEADBEEF, lat, e, q);
        check("l0_wr_lat", lat, 1);
        check("l0_wr_rdata", q, 32'd0);
        acc(0, 1, 0, 2'd2, 32'h40, 32'h0, lat, e, q);
        check("l0_rd_lat", lat, 1);
        check("l0_rd_err", {31'd0, e}, 32'd0);
        check("l0_rd_data", q, 32'hDEADBEEF);
        acc(0, 1, 0, 2'd2, 32'h42, 32'h0, lat, e, q);
        check("mis_lat", lat, 1);
        check("mis_err", {31'd0, e}, 32'd1);
        check("mis_rdata", q, EALIGN);
        acc(0, 1, 0, 2'd2, 32'h40, 32'h0, lat, e, q);
        check("mis_unchanged", q, 32'hDEADBEEF);
        acc(0, 0, 1, 2'd1, 32'h42, 32'h55660000, lat, e, q);
        check("half_wr_err", {31'd0, e}, 32'd0);
        acc(0, 1, 0, 2'd2, 32'h40, 32'h0, lat, e, q);
        check("half_rd_data", q, 32'h5566BEEF);
        acc(0, 1, 0, 2'd3, 32'h40, 32'h0, lat, e, q);
        check("size8_err", {31'd0, e}, 32'd1);
        acc(0, 1, 1, 2'd2, 32'h40, 32'h0, lat, e, q);
        check("rewe_err", {31'd0, e}, 32'd1);
        check("rewe_rdata", q, EALIGN);
        acc(0, 1, 0, 2'd2, 32'h40, 32'h0, lat, e, q);
        check("rewe_unchanged", q, 32'h5566BEEF);

        // back-to-back reads held with no gap
        @(negedge clk);
        re[0] = 1'b1; asize[0] = 2'd2; addr[0] = 32'h40;
        pat = '0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            pat[c] = rdy[0];
        end
        re[0] = 1'b0;
        check("b2b_pattern", {28'd0, pat}, 32'h5);
        repeat (2) @(posedge clk);

        // latency 3
        acc(1, 0, 1, 2'd2, 32'h40, 32'h11223344, lat, e, q);
        check("l3_wr_lat", lat, 4);
        acc(1, 0, 1, 2'd0, 32'h41, 32'h0000AB00, lat, e, q);
        check("l3_byte_lat", lat, 4);
        acc(1, 1, 0, 2'd2, 32'h40, 32'h0, lat, e, q);
        check("l3_rd_lat", lat, 4);
        check("l3_byte_data", q, 32'h1122AB44);
        acc(1, 1, 0, 2'd1, 32'h41, 32'h0, lat, e, q);
        check("l3_mis_lat", lat, 1);
        check("l3_mis_err", {31'd0, e}, 32'd1);

        // latency 5: abort in the second wait cycle
        acc(2, 0, 1, 2'd2, 32'h80, 32'hCAFEF00D, lat, e, q);
        check("l5_wr_lat", lat, 6);
        @(negedge clk);
        we[2] = 1'b1; asize[2] = 2'd2; addr[2] = 32'h80; wdata[2] = 32'h12345678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        we[2] = 1'b0;
        seen = 1'b0;
        @(posedge clk); #1;
        seen |= rdy[2];
        acc(2, 1, 0, 2'd2, 32'h80, 32'h0, lat, e, q);
        check("abort_no_ready", {31'd0, seen}, 32'd0);
        check("abort_idle_lat", lat, 6);
        check("abort_unchanged", q, 32'hCAFEF00D);

        // latency 4: reset during wait
        acc(3, 0, 1, 2'd2, 32'hC0, 32'hA5A5A5A5, lat, e, q);
        check("l4_wr_lat", lat, 5);
        @(negedge clk);
        we[3] = 1'b1; asize[3] = 2'd2; addr[3] = 32'hC0; wdata[3] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstw_ready", {31'd0, rdy[3]}, 32'd0);
        check("rstw_error", {31'd0, err[3]}, 32'd0);
        check("rstw_rdata", rdat[3], 32'd0);
        rst = 1'b0;
        we[3] = 1'b0;
        acc(3, 1, 0, 2'd2, 32'hC0, 32'h0, lat, e, q);
        check("rstw_unchanged", q, 32'hA5A5A5A5);
        check("rstw_rd_lat", lat, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
